local_inject_sched: RTL and testbench

- Injection scheduler between node-local traffic sources and the two local injection ports (portl0/portl1) of a hierarchical-ring node router.
- Arbitrates NREQ requesters round-robin onto two lanes.
- Holds each flit on its lane until the router's per-lane ack.
- Flags lanes starved by through-traffic on the ring.

---
 rtl/local_inject_sched_pkg.sv | 9 +
 rtl/rr_arb2.sv | 35 +++
 rtl/local_inject_sched.sv | 110 +++++++++++
 tb/tb_local_inject_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/local_inject_sched_pkg.sv
// Shared widths and lane encodings for the local injection scheduler.
// Also reused by the ring-port schedulers.
package local_inject_sched_pkg;
  localparam int CONTROL_W = 144;
  localparam int FLIT_VALID = CONTROL_W - 1;
  localparam int AGE_W = 8;
  localparam logic [0:0] LANE_IDLE = 1'b0;
  localparam logic [0:0] LANE_HOLD = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Round-robin arbiter that grants up to two requesters onto two lanes.
// Purely combinational.
module rr_arb2 #(
  parameter int NREQ = 4,
  parameter int PW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic [1:0]      free,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] lane,
  output logic [PW-1:0]   next_ptr
);
  int idx;
  logic [1:0] avail;

  always_comb begin
    grant = '0;
    lane = '0;
    next_ptr = ptr;
    avail = free;
    idx = 0;
    for (int j = 0; j < NREQ; j++) begin
      idx = (int'(ptr) + j) % NREQ;
      // first winner takes lane 0 when it is free, second takes the rest
      if (req[idx] && avail != 2'b00) begin
        grant[idx] = 1'b1;
        lane[idx] = ~avail[0];
        if (avail[0]) avail[0] = 1'b0;
        else avail[1] = 1'b0;
        next_ptr = PW'((idx + 1) % NREQ);
      end
    end
  end
endmodule

// File: rtl/local_inject_sched.sv
// Injection scheduler from node-local requesters onto the two
// local router injection lanes, with ack hold and starvation flags.
module local_inject_sched
  import local_inject_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int FLIT_W = CONTROL_W,
  parameter int STARVE_LIM = 63,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*FLIT_W-1:0] req_flit,
  output logic [NREQ-1:0]        req_ready,
  output logic [FLIT_W-1:0]      portl0_ci,
  output logic [FLIT_W-1:0]      portl1_ci,
  input  logic                   portl0_ack,
  input  logic                   portl1_ack,
  output logic [1:0]             starve,
  output logic [CNT_W-1:0]       inj_count
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] nxt_ptr;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] lane_sel;
  logic [1:0] ack;
  logic [1:0] free;
  logic [1:0] ld;
  logic [1:0] inj;
  logic [0:0] lane_st [2];
  logic [FLIT_W-1:0] ld_flit [2];
  logic [FLIT_W-1:0] lane_flit [2];
  logic [AGE_W-1:0] lane_age [2];

  assign ack = {portl1_ack, portl0_ack};

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      free[k] = (lane_st[k] == LANE_IDLE) | ack[k];
      inj[k] = (lane_st[k] == LANE_HOLD) & ack[k];
    end
  end

  rr_arb2 #(
    .NREQ(NREQ),
    .PW(PW)
  ) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .free(free),
    .grant(grant),
    .lane(lane_sel),
    .next_ptr(nxt_ptr)
  );

  assign req_ready = grant & {NREQ{rst}};

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      ld[k] = 1'b0;
      ld_flit[k] = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i] && lane_sel[i] == 1'(k)) begin
          ld[k] = 1'b1;
          ld_flit[k] = req_flit[i*FLIT_W +: FLIT_W];
        end
      end
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_lane
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lane_st[k] <= LANE_IDLE;
        lane_flit[k] <= '0;
        lane_age[k] <= '0;
      end else if (ld[k]) begin
        lane_st[k] <= LANE_HOLD;
        lane_flit[k] <= ld_flit[k];
        lane_age[k] <= '0;
      end else if (ack[k]) begin
        lane_st[k] <= LANE_IDLE;
        lane_flit[k] <= '0;
        lane_age[k] <= '0;
      end else if (lane_st[k] == LANE_HOLD &&
                   lane_age[k] != AGE_W'(STARVE_LIM)) begin
        lane_age[k] <= lane_age[k] + 1'b1;
      end
    end

    assign starve[k] = (lane_st[k] == LANE_HOLD) &&
                       (lane_age[k] == AGE_W'(STARVE_LIM));
  end

  assign portl0_ci = lane_flit[0];
  assign portl1_ci = lane_flit[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      inj_count <= '0;
    end else begin
      if (|grant) rr_ptr <= nxt_ptr;
      inj_count <= inj_count + CNT_W'(inj[0]) + CNT_W'(inj[1]);
    end
  end
endmodule

// File: tb/tb_local_inject_sched.sv
// Scoreboard bench for local_inject_sched (NREQ=4, CNT_W=4).
// Scenario tasks run in sequence from one initial block.
module tb_local_inject_sched;
  localparam int FW = 144;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] req_valid = '0;
  logic [4*FW-1:0] req_flit = '0;
  logic [3:0] req_ready;
  logic [FW-1:0] p0;
  logic [FW-1:0] p1;
  logic p0a = 1'b0;
  logic p1a = 1'b0;
  logic [1:0] starve;
  logic [3:0] inj_count;

  logic [FW-1:0] q0 [$];
  logic [FW-1:0] q1 [$];
  logic [3:0] qr [$];
  logic [FW-1:0] e0;
  logic [FW-1:0] e1;
  logic [3:0] er;
  logic [3:0] exp_cnt;
  int n_chk = 0;
  int n_fail = 0;

  local_inject_sched #(
    .NREQ(4),
    .FLIT_W(FW),
    .STARVE_LIM(63),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_flit(req_flit),
    .req_ready(req_ready),
    .portl0_ci(p0),
    .portl1_ci(p1),
    .portl0_ack(p0a),
    .portl1_ack(p1a),
    .starve(starve),
    .inj_count(inj_count)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input logic [15:0] v);
    return {9{v}};
  endfunction

  task automatic set_flit(input int i, input logic [15:0] v);
    req_flit[i*FW +: FW] = mk(v);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_ready: got %b want 0000", req_ready);
      end
      n_chk++;
      if (p0 !== '0 || p1 !== '0) begin
        n_fail++;
        $display("FAIL reset_ci: got %h / %h want 0", p0, p1);
      end
      n_chk++;
      if (starve !== 2'b00 || inj_count !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_flags: starve %b cnt %0d want 0", starve, inj_count);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if (req_ready !== 4'b0011) begin
      n_fail++;
      $display("FAIL release_ready: got %b want 0011", req_ready);
    end
    req_valid = 4'b0000;
    exp_cnt = 4'd0;
  endtask

  task automatic test_single;
    @(negedge clk);
    set_flit(2, 16'hA0A0);
    req_valid = 4'b0100;
    q0.push_back(mk(16'hA0A0));
    #1;
    n_chk++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    @(posedge clk);
    #1;
    e0 = q0.pop_front();
    n_chk++;
    if (p0 !== e0 || p1 !== '0) begin
      n_fail++;
      $display("FAIL single_load: got %h / %h want %h / 0", p0, p1, e0);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_chk++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_idle_ready: got %b want 0000", req_ready);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (p0 !== e0) begin
      n_fail++;
      $display("FAIL single_hold: got %h want %h", p0, e0);
    end
    @(negedge clk);
    p0a = 1'b1;
    @(posedge clk);
    exp_cnt = exp_cnt + 4'd1;
    #1;
    n_chk++;
    if (p0 !== '0 || inj_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL single_ack: ci %h cnt %0d want 0 cnt %0d", p0, inj_count, exp_cnt);
    end
    @(negedge clk);
    p0a = 1'b0;
  endtask

  task automatic test_round_robin;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 4'd0;
    for (int i = 0; i < 4; i++) set_flit(i, 16'h0010 + 16'(i));
    qr.push_back(4'b0011);
    qr.push_back(4'b1100);
    qr.push_back(4'b0011);
    q0.push_back(mk(16'h0010));
    q0.push_back(mk(16'h0012));
    q0.push_back(mk(16'h0010));
    q1.push_back(mk(16'h0011));
    q1.push_back(mk(16'h0013));
    q1.push_back(mk(16'h0011));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 4'b1111;
      p0a = 1'b1;
      p1a = 1'b1;
      #1;
      er = qr.pop_front();
      n_chk++;
      if (req_ready !== er) begin
        n_fail++;
        $display("FAIL rr_ready%0d: got %b want %b", c, req_ready, er);
      end
      @(posedge clk);
      if (c > 0) exp_cnt = exp_cnt + 4'd2;
      #1;
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      n_chk++;
      if (p0 !== e0 || p1 !== e1) begin
        n_fail++;
        $display("FAIL rr_lanes%0d: got %h / %h want %h / %h", c, p0, p1, e0, e1);
      end
      n_chk++;
      if (inj_count !== exp_cnt) begin
        n_fail++;
        $display("FAIL rr_count%0d: got %0d want %0d", c, inj_count, exp_cnt);
      end
    end
    @(negedge clk);
    req_valid = 4'b0000;
    @(posedge clk);
    exp_cnt = exp_cnt + 4'd2;
    #1;
    n_chk++;
    if (p0 !== '0 || p1 !== '0 || inj_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL rr_drain: ci %h / %h cnt %0d want 0 / 0 cnt %0d", p0, p1, inj_count, exp_cnt);
    end
    @(negedge clk);
    p0a = 1'b0;
    p1a = 1'b0;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    set_flit(2, 16'hAAAA);
    req_valid = 4'b0100;
    q0.push_back(mk(16'hAAAA));
    q0.push_back(mk(16'hBBBB));
    @(posedge clk);
    #1;
    e0 = q0.pop_front();
    n_chk++;
    if (p0 !== e0) begin
      n_fail++;
      $display("FAIL b2b_first: got %h want %h", p0, e0);
    end
    @(negedge clk);
    set_flit(2, 16'hBBBB);
    p0a = 1'b1;
    #1;
    n_chk++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL b2b_ready: got %b want 0100", req_ready);
    end
    @(posedge clk);
    exp_cnt = exp_cnt + 4'd1;
    #1;
    e0 = q0.pop_front();
    n_chk++;
    if (p0 !== e0 || p1 !== '0 || inj_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL b2b_reload: got %h cnt %0d want %h cnt %0d", p0, inj_count, e0, exp_cnt);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    @(posedge clk);
    exp_cnt = exp_cnt + 4'd1;
    #1;
    n_chk++;
    if (p0 !== '0 || inj_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL b2b_drain: got %h cnt %0d want 0 cnt %0d", p0, inj_count, exp_cnt);
    end
    @(negedge clk);
    p0a = 1'b0;
  endtask

  task automatic test_starve;
    logic exp_st;
    @(negedge clk);
    set_flit(3, 16'hCCCC);
    req_valid = 4'b1000;
    #1;
    n_chk++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL starve_ready: got %b want 1000", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    for (int n = 1; n <= 70; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      exp_st = (n >= 64);
      n_chk++;
      if (starve !== {1'b0, exp_st}) begin
        n_fail++;
        $display("FAIL starve_cyc%0d: got %b want %b", n, starve, {1'b0, exp_st});
      end
    end
    @(negedge clk);
    set_flit(0, 16'hDDDD);
    req_valid = 4'b0001;
    #1;
    n_chk++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL starve_lane1_ready: got %b want 0001", req_ready);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (p0 !== mk(16'hCCCC) || p1 !== mk(16'hDDDD) || starve !== 2'b01) begin
      n_fail++;
      $display("FAIL starve_lane1: %h / %h st %b want cccc / dddd st 01", p0[15:0], p1[15:0], starve);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    p0a = 1'b1;
    p1a = 1'b1;
    @(posedge clk);
    exp_cnt = exp_cnt + 4'd2;
    #1;
    n_chk++;
    if (starve !== 2'b00 || inj_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL starve_clear: st %b cnt %0d want 00 cnt %0d", starve, inj_count, exp_cnt);
    end
    @(negedge clk);
    p0a = 1'b0;
    p1a = 1'b0;
  endtask

  task automatic test_wrap_spurious;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 4'd0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      p0a = 1'b1;
      p1a = 1'b1;
      @(posedge clk);
      if (c > 0) exp_cnt = exp_cnt + 4'd2;
      #1;
      n_chk++;
      if (inj_count !== exp_cnt) begin
        n_fail++;
        $display("FAIL wrap_count%0d: got %0d want %0d", c, inj_count, exp_cnt);
      end
    end
    n_chk++;
    if (inj_count !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_zero: got %0d want 0", inj_count);
    end
    @(negedge clk);
    p0a = 1'b0;
    p1a = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (inj_count !== exp_cnt || p1 !== '0 || p0 !== '0) begin
      n_fail++;
      $display("FAIL spurious_ack: cnt %0d ci1 %h want cnt %0d ci1 0", inj_count, p1, exp_cnt);
    end
    @(negedge clk);
    p1a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_starve();
    test_wrap_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
